// File: rtl/multiplicador_pkg.sv
// Shared definitions for the sequential shift-add multiplier:
// the FSM state encoding, the default operand width and the iteration counter width.
package multiplicador_pkg;

  localparam int LARGURA_PADRAO = 16;
  localparam int CONT_W         = $clog2(LARGURA_PADRAO);

  // The code 2'b11 is unused and falls back to OCIOSO.
  localparam logic [1:0] OCIOSO   = 2'b00;
  localparam logic [1:0] CALCULA  = 2'b01;
  localparam logic [1:0] FINALIZA = 2'b10;

endpackage

// File: rtl/multiplicador_seq_if.sv
// Control-unit <-> multiplier bus: operands and start request in, product halves and status out.
interface multiplicador_seq_if
  import multiplicador_pkg::*;
#(
  parameter int LARGURA = LARGURA_PADRAO
);

  // Handshake: inicio is a request that is honoured only when the multiplier is idle
  // (ocupado=0). The operands and sinal are captured on that same edge. Requests made
  // while ocupado=1 are dropped. pronto is a one-cycle strobe: saida_hi and saida_lo
  // have just been updated and then stay stable until the next pronto. There is no
  // back-pressure.
  logic               inicio;
  logic               sinal;
  logic [LARGURA-1:0] entrada_a;
  logic [LARGURA-1:0] entrada_b;
  logic [LARGURA-1:0] saida_hi;
  logic [LARGURA-1:0] saida_lo;
  logic               pronto;
  logic               ocupado;
  logic [1:0]         estado;

  modport master (
    output inicio, sinal, entrada_a, entrada_b,
    input  saida_hi, saida_lo, pronto, ocupado, estado
  );

  modport slave (
    input  inicio, sinal, entrada_a, entrada_b,
    output saida_hi, saida_lo, pronto, ocupado, estado
  );

endinterface

// File: rtl/multiplicador_seq.sv
// Multi-cycle LARGURA x LARGURA shift-add multiplier with fixed LARGURA+1 cycle latency.
// Signed operands are handled as sign-magnitude: magnitudes are multiplied and the product is negated at the end.
module multiplicador_seq
  import multiplicador_pkg::*;
#(
  parameter int LARGURA = LARGURA_PADRAO
) (
  input logic               clock,
  input logic               reset,
  multiplicador_seq_if.slave bus
);

  localparam int CW = (LARGURA == LARGURA_PADRAO) ? CONT_W : $clog2(LARGURA);
  localparam logic [CW-1:0] ULTIMO = CW'(LARGURA - 1);

  logic [1:0]           r_estado;
  logic [LARGURA-1:0]   r_mcand;
  logic [LARGURA-1:0]   r_mult;
  logic [2*LARGURA-1:0] r_acc;
  logic [CW-1:0]        r_cont;
  logic                 r_neg;
  logic                 r_pronto;
  logic [LARGURA-1:0]   r_hi;
  logic [LARGURA-1:0]   r_lo;

  logic [LARGURA-1:0]   w_mag_a;
  logic [LARGURA-1:0]   w_mag_b;
  logic [LARGURA:0]     w_soma;
  logic [2*LARGURA-1:0] w_result;

  // Conditional two's-complement negation; used for operand magnitudes and for the final sign.
  function automatic logic [2*LARGURA-1:0] f_neg_cond(input logic neg,
                                                      input logic [2*LARGURA-1:0] v);
    return neg ? (~v + {{(2*LARGURA-1){1'b0}}, 1'b1}) : v;
  endfunction

  assign w_mag_a = LARGURA'(f_neg_cond(bus.sinal & bus.entrada_a[LARGURA-1],
                                       {{LARGURA{1'b0}}, bus.entrada_a}));
  assign w_mag_b = LARGURA'(f_neg_cond(bus.sinal & bus.entrada_b[LARGURA-1],
                                       {{LARGURA{1'b0}}, bus.entrada_b}));

  // Carry out of the upper-half add is kept as the top bit and shifted back in.
  assign w_soma   = {1'b0, r_acc[2*LARGURA-1:LARGURA]} +
                    (r_mult[0] ? {1'b0, r_mcand} : {(LARGURA+1){1'b0}});
  assign w_result = f_neg_cond(r_neg, r_acc);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado <= OCIOSO;
      r_mcand  <= '0;
      r_mult   <= '0;
      r_acc    <= '0;
      r_cont   <= '0;
      r_neg    <= 1'b0;
      r_pronto <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_pronto <= 1'b0;
      case (r_estado)
        OCIOSO: begin
          if (bus.inicio) begin
            r_mcand  <= w_mag_a;
            r_mult   <= w_mag_b;
            r_neg    <= bus.sinal & (bus.entrada_a[LARGURA-1] ^ bus.entrada_b[LARGURA-1]);
            r_acc    <= '0;
            r_cont   <= '0;
            r_estado <= CALCULA;
          end
        end
        CALCULA: begin
          r_acc  <= {w_soma, r_acc[LARGURA-1:1]};
          r_mult <= r_mult >> 1;
          r_cont <= r_cont + 1'b1;
          if (r_cont == ULTIMO) begin
            r_estado <= FINALIZA;
          end
        end
        FINALIZA: begin
          r_hi     <= w_result[2*LARGURA-1:LARGURA];
          r_lo     <= w_result[LARGURA-1:0];
          r_pronto <= 1'b1;
          r_estado <= OCIOSO;
        end
        default: begin
          r_estado <= OCIOSO;
        end
      endcase
    end
  end

  assign bus.saida_hi = r_hi;
  assign bus.saida_lo = r_lo;
  assign bus.pronto   = r_pronto;
  assign bus.ocupado  = (r_estado == CALCULA) || (r_estado == FINALIZA);
  assign bus.estado   = r_estado;

endmodule

// File: tb/tb_multiplicador_seq.sv
// Self-checking bench for multiplicador_seq: directed cases from the test plan plus random
// operations, with a scoreboard queue of expected products popped on every pronto.
module tb_multiplicador_seq;
  import multiplicador_pkg::*;

  localparam int L = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;

  logic [2*L-1:0] exp_q[$];

  multiplicador_seq_if #(.LARGURA(L)) bus ();

  multiplicador_seq #(.LARGURA(L)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h", tag, obs, expv);
    end
  endtask

  function automatic logic [2*L-1:0] modelo(input logic [L-1:0] a, input logic [L-1:0] b,
                                             input logic s);
    longint p;
    if (s) p = longint'($signed(a)) * longint'($signed(b));
    else   p = longint'(a) * longint'(b);
    return p[2*L-1:0];
  endfunction

  // Scoreboard: every pronto must match the oldest outstanding expectation.
  always @(posedge clock) begin
    logic [2*L-1:0] e;
    #1;
    if (bus.pronto) begin
      if (exp_q.size() == 0) begin
        chk("pronto_extra", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("product", {bus.saida_hi, bus.saida_lo}, e);
      end
    end
  end

  // Called #1 after a clock edge; returns #1 after the accepting edge.
  task automatic start(input logic [L-1:0] a, input logic [L-1:0] b, input logic s,
                       input bit push);
    bus.entrada_a = a;
    bus.entrada_b = b;
    bus.sinal     = s;
    bus.inicio    = 1'b1;
    if (push) exp_q.push_back(modelo(a, b, s));
    @(posedge clock);
    #1;
    bus.inicio = 1'b0;
  endtask

  task automatic wait_pronto(input string tag, output int lat, output int ocup);
    lat  = 0;
    ocup = bus.ocupado ? 1 : 0;
    while (lat < 40) begin
      @(posedge clock);
      #1;
      lat++;
      if (bus.pronto) break;
      if (bus.ocupado) ocup++;
    end
    if (!bus.pronto) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, ocup;
    bus.inicio    = 1'b0;
    bus.sinal     = 1'b0;
    bus.entrada_a = '0;
    bus.entrada_b = '0;

    repeat (3) @(posedge clock);
    #1;
    chk("rst_prod",    {bus.saida_hi, bus.saida_lo}, 32'h0);
    chk("rst_pronto",  32'(bus.pronto), 32'd0);
    chk("rst_ocupado", 32'(bus.ocupado), 32'd0);
    chk("rst_estado",  32'(bus.estado), 32'(OCIOSO));
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Unsigned 3x5: latency, ocupado window, one-cycle pronto.
    start(16'd3, 16'd5, 1'b0, 1'b1);
    wait_pronto("t1", lat, ocup);
    chk("t1_latency", 32'(lat), 32'd17);
    chk("t1_ocupado_cycles", 32'(ocup), 32'd17);
    chk("t1_ocupado_at_pronto", 32'(bus.ocupado), 32'd0);
    chk("t1_prod", {bus.saida_hi, bus.saida_lo}, 32'h0000_000F);
    @(posedge clock);
    #1;
    chk("t1_pronto_width", 32'(bus.pronto), 32'd0);
    chk("t1_hold", {bus.saida_hi, bus.saida_lo}, 32'h0000_000F);

    start(16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
    wait_pronto("t2", lat, ocup);
    chk("t2_prod", {bus.saida_hi, bus.saida_lo}, 32'hFFFE_0001);

    start(16'hFFFE, 16'h0003, 1'b1, 1'b1);
    wait_pronto("t3", lat, ocup);
    chk("t3_prod", {bus.saida_hi, bus.saida_lo}, 32'hFFFF_FFFA);

    start(16'h8000, 16'h8000, 1'b1, 1'b1);
    wait_pronto("t4", lat, ocup);
    chk("t4_prod", {bus.saida_hi, bus.saida_lo}, 32'h4000_0000);

    // Busy start ignored, then a start in the pronto cycle is accepted.
    start(16'd7, 16'd9, 1'b0, 1'b1);
    repeat (4) @(posedge clock);
    #1;
    bus.entrada_a = 16'd2;
    bus.entrada_b = 16'd2;
    bus.inicio    = 1'b1;
    @(posedge clock);
    #1;
    bus.inicio = 1'b0;
    wait_pronto("t5", lat, ocup);
    chk("t5_latency", 32'(lat), 32'd12);
    chk("t5_prod", {bus.saida_hi, bus.saida_lo}, 32'h0000_003F);
    start(16'd2, 16'd2, 1'b0, 1'b1);
    wait_pronto("t6", lat, ocup);
    chk("t6_latency", 32'(lat), 32'd17);
    chk("t6_prod", {bus.saida_hi, bus.saida_lo}, 32'h0000_0004);

    // Random back-to-back operations, mixed signedness.
    for (int i = 0; i < 8; i++) begin
      start(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
            1'($urandom_range(0, 1)), 1'b1);
      wait_pronto("rnd", lat, ocup);
      chk("rnd_latency", 32'(lat), 32'd17);
    end

    // Reset in the middle of an operation clears everything at once.
    start(16'd5, 16'd6, 1'b0, 1'b0);
    repeat (7) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk("mid_rst_prod",    {bus.saida_hi, bus.saida_lo}, 32'h0);
    chk("mid_rst_pronto",  32'(bus.pronto), 32'd0);
    chk("mid_rst_ocupado", 32'(bus.ocupado), 32'd0);
    chk("mid_rst_estado",  32'(bus.estado), 32'(OCIOSO));
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    start(16'd4, 16'd4, 1'b0, 1'b1);
    wait_pronto("t7", lat, ocup);
    chk("t7_latency", 32'(lat), 32'd17);
    chk("t7_prod", {bus.saida_hi, bus.saida_lo}, 32'h0000_0010);

    // Hold: operands wiggle with inicio low; outputs must not move.
    for (int i = 0; i < 50; i++) begin
      bus.entrada_a = 16'($urandom_range(0, 65535));
      bus.entrada_b = 16'($urandom_range(0, 65535));
      bus.sinal     = 1'($urandom_range(0, 1));
      @(posedge clock);
      #1;
      chk("hold_prod", {bus.saida_hi, bus.saida_lo}, 32'h0000_0010);
      chk("hold_pronto", 32'(bus.pronto), 32'd0);
    end

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
